i2s_frame_tx: RTL and testbench

Parallel-to-I2S transmitter that consumes stereo sample pairs from the Raspberry Pi receive path and serializes them onto the DAC serial lines. It generates its own bit clock (sck) and word-select (lrck) from the single system clock, double-buffers one pending sample pair, and reports each frame boundary and each underrun. It sits directly downstream of the RPi data input stage and replaces the free-running shift/divider path feeding `serial`/`lr_clk`.

---
 rtl/i2s_pkg.sv | 38 +++
 rtl/i2s_sck_gen.sv | 53 +++++
 rtl/i2s_frame_tx.sv | 141 ++++++++++++++
 tb/tb_i2s_frame_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared constants and helpers for the I2S frame transmitter.
//   SAMPLE_W_DEF  default bits per channel
//   FRAME_SLOTS   slots per stereo frame at the default width
//   LRCK_LEFT     word-select level that marks the left channel
//   HOLD_*        holding-register states
//   frame_evt_t   registered per-frame event pulses
//   lrck_for_slot word-select level for a given slot (Philips timing)
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAME_SLOTS  = 2 * SAMPLE_W_DEF;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = ~LRCK_LEFT;

  // Holding register is a two-state machine: empty or carrying one pair.
  localparam logic [0:0] HOLD_EMPTY = 1'b0;
  localparam logic [0:0] HOLD_FULL  = 1'b1;

  typedef struct packed {
    logic frame_start;
    logic underrun;
  } frame_evt_t;

  // Word select leads the data by one slot: it switches to the right
  // channel on the last left bit and back on the last right bit.
  function automatic logic lrck_for_slot(input int unsigned slot,
                                         input int unsigned sample_w);
    if ((slot >= sample_w - 1) && (slot <= 2 * sample_w - 2)) begin
      return LRCK_RIGHT;
    end
    return LRCK_LEFT;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// ---------------------------------------------------------------------------
// i2s_sck_gen
// Divides the system clock down to the I2S bit clock.
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   sck       out  bit clock, low for the first half of each period
//   fall_stb  out  high for the one clk cycle in which the divider wraps;
//                  state updated on that edge changes together with sck
//                  falling
// ---------------------------------------------------------------------------
module i2s_sck_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic sck,
  output logic fall_stb
);

  localparam int CNT_W = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCK_DIV / 2);

  if ((SCK_DIV < 2) || (SCK_DIV % 2 != 0)) begin : g_bad_sck_div
    $error("i2s_sck_gen: SCK_DIV must be even and at least 2");
  end

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;
    // sck is registered from the next count so the pin never glitches,
    // while still equalling (div_cnt >= SCK_DIV/2) in every cycle.
    sck_d     = (div_cnt_d >= CNT_HALF);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign fall_stb = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/i2s_frame_tx.sv
// ---------------------------------------------------------------------------
// i2s_frame_tx
// Parallel-to-I2S transmitter with a one-pair holding register.
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   in_valid     in   sample pair offered
//   in_ready     out  holding register empty; pair taken on valid && ready
//   in_left      in   left sample, two's complement
//   in_right     in   right sample, two's complement
//   sck          out  I2S bit clock
//   lrck         out  word select, 0 = left
//   sdata        out  serial data, MSB first
//   frame_start  out  one-clk pulse after each frame load
//   underrun     out  one-clk pulse after a frame load that found no pair
// Frame length is 2*SAMPLE_W*SCK_DIV clk cycles; a pair accepted during
// one frame is transmitted in the next.
// ---------------------------------------------------------------------------
module i2s_frame_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                sck,
  output logic                lrck,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int SLOT_CNT = 2 * SAMPLE_W;
  localparam int SLOT_W   = $clog2(SLOT_CNT);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CNT - 1);

  if ((SAMPLE_W < 8) || (SAMPLE_W > 32) || (SAMPLE_W % 2 != 0)) begin : g_bad_sample_w
    $error("i2s_frame_tx: SAMPLE_W must be even and in 8..32");
  end

  logic fall_stb;
  logic load_evt;
  logic accept;

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                lrck_q, lrck_d;
  logic [SLOT_CNT-1:0] shift_q, shift_d;
  logic [0:0]          hold_state_q, hold_state_d;
  logic [SLOT_CNT-1:0] hold_data_q, hold_data_d;
  logic                in_ready_q, in_ready_d;
  frame_evt_t          evt_q, evt_d;

  i2s_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .fall_stb (fall_stb)
  );

  always_comb begin
    // NOTE: every signal driven here gets its hold value first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    slot_d       = slot_q;
    lrck_d       = lrck_q;
    shift_d      = shift_q;
    hold_state_d = hold_state_q;
    hold_data_d  = hold_data_q;
    evt_d        = '0;

    // A frame is loaded on the sck falling event that closes the last slot.
    load_evt = fall_stb && (slot_q == SLOT_LAST);
    accept   = in_valid && in_ready_q;

    if (fall_stb) begin
      slot_d = load_evt ? '0 : slot_q + 1'b1;
      lrck_d = lrck_for_slot(32'(slot_d), SAMPLE_W);
    end

    if (load_evt) begin
      if (hold_state_q == HOLD_FULL) begin
        shift_d      = hold_data_q;
        hold_state_d = HOLD_EMPTY;
      end else begin
        // Nothing pending: send a silent frame and flag it.
        shift_d        = '0;
        evt_d.underrun = 1'b1;
      end
      evt_d.frame_start = 1'b1;
    end else if (fall_stb) begin
      shift_d = {shift_q[SLOT_CNT-2:0], 1'b0};
    end

    // in_ready is low whenever the holding register is full, so an accept
    // can coincide with a load only when the load found it empty; the new
    // pair then waits for the following frame.
    if (accept) begin
      hold_state_d = HOLD_FULL;
      hold_data_d  = {in_left, in_right};
    end

    in_ready_d = (hold_state_d == HOLD_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      lrck_q       <= LRCK_LEFT;
      shift_q      <= '0;
      hold_state_q <= HOLD_EMPTY;
      in_ready_q   <= 1'b1;
      evt_q        <= '0;
    end else begin
      slot_q       <= slot_d;
      lrck_q       <= lrck_d;
      shift_q      <= shift_d;
      hold_state_q <= hold_state_d;
      in_ready_q   <= in_ready_d;
      evt_q        <= evt_d;
    end
  end

  // NOTE: the holding data needs no reset; it is only read when
  // hold_state_q says it was written, and keeping it out of the reset
  // tree leaves a plain enable register.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

  assign in_ready    = in_ready_q;
  assign lrck        = lrck_q;
  assign sdata       = shift_q[SLOT_CNT-1];
  assign frame_start = evt_q.frame_start;
  assign underrun    = evt_q.underrun;

endmodule

// File: tb/tb_i2s_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_frame_tx
// Scoreboard bench for i2s_frame_tx: a default instance (16-bit, /4) driven
// with directed and random pairs, plus a 24-bit /2 instance.
// ---------------------------------------------------------------------------
module tb_i2s_frame_tx;

  localparam int W     = i2s_pkg::SAMPLE_W_DEF;
  localparam int SLOTS = i2s_pkg::FRAME_SLOTS;
  localparam int DIV   = 4;
  localparam int FRAME = SLOTS * DIV;

  localparam int W2     = 24;
  localparam int DIV2   = 2;
  localparam int FRAME2 = 2 * W2 * DIV2;

  typedef struct {
    int           acc_edge;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  logic         clk;
  logic         rst, in_valid, in_ready, sck, lrck, sdata, frame_start, underrun;
  logic [W-1:0] in_left, in_right;

  logic          rst2, in_valid2, in_ready2, sck2, lrck2, sdata2, frame_start2, underrun2;
  logic [W2-1:0] in_left2, in_right2;

  int    total = 0;
  int    bad   = 0;
  int    p;               // rising edges since dut reset release
  bit    junk_en;
  pair_t exp_q[$];

  i2s_frame_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .sck(sck), .lrck(lrck),
    .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
  );

  i2s_frame_tx #(.SAMPLE_W(W2), .SCK_DIV(DIV2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_left(in_left2), .in_right(in_right2), .sck(sck2), .lrck(lrck2),
    .sdata(sdata2), .frame_start(frame_start2), .underrun(underrun2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) p <= 0;
    else     p <= p + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Offer a pair; while in_ready is low, optionally hold in_valid high
  // with junk data that must not be captured.
  task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
    int waited = 0;
    forever begin
      @(posedge clk); #1;
      if (in_ready) begin
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        exp_q.push_back('{acc_edge: p + 1, l: l, r: r});
        return;
      end
      in_valid = junk_en;
      in_left  = W'($urandom);
      in_right = W'($urandom);
      waited++;
      if (waited > 3 * FRAME) begin
        total++;
        bad++;
        $display("FAIL ready_wait: got=timeout expected=in_ready");
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_left  = W'($urandom);
    end
  endtask

  // Monitor: rebuilds each frame from sdata/lrck sampled at sck rising and
  // compares against the pair the scoreboard says the frame must carry.
  initial begin : monitor
    logic [SLOTS-1:0] got_bits, got_lr, exp_bits, lr_exp;
    int               nbits;
    logic             prev_sck, exp_fs, loaded, exp_ready;
    pair_t            pr;
    for (int k = 0; k < SLOTS; k++) lr_exp[SLOTS-1-k] = (k >= W - 1) && (k <= 2 * W - 2);
    got_bits = '0; got_lr = '0; exp_bits = '0; nbits = 0; prev_sck = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        got_bits = '0; got_lr = '0; exp_bits = '0; nbits = 0; prev_sck = 1'b0;
      end else begin
        exp_fs = (p > 0) && (p % FRAME == 0);
        if (frame_start || exp_fs) check("frame_start", 64'(frame_start), 64'(exp_fs));
        if (underrun && !exp_fs)   check("underrun_stray", 64'(underrun), 64'd0);
        if (exp_fs) begin
          check("frame_len", 64'(nbits), 64'(SLOTS));
          check("frame_data", 64'(got_bits), 64'(exp_bits));
          check("frame_lrck", 64'(got_lr), 64'(lr_exp));
          // A pair is carried if it was accepted on an edge before the load.
          loaded = (exp_q.size() > 0) && (exp_q[0].acc_edge < p);
          if (loaded) begin
            pr       = exp_q.pop_front();
            exp_bits = {pr.l, pr.r};
          end else begin
            exp_bits = '0;
          end
          check("underrun", 64'(underrun), 64'(!loaded));
          got_bits = '0; got_lr = '0; nbits = 0;
        end
        exp_ready = !((exp_q.size() > 0) && (exp_q[0].acc_edge <= p));
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        if (sck && !prev_sck) begin
          got_bits = {got_bits[SLOTS-2:0], sdata};
          got_lr   = {got_lr[SLOTS-2:0], lrck};
          nbits++;
        end
        prev_sck = sck;
      end
    end
  end

  initial begin : main
    int               n;
    int               slot;
    int               e_sck, e_lr, e_sd, e_pulse;
    logic [2*W2-1:0]  pair2;
    logic             exp_sd;

    rst = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0; junk_en = 1'b0;
    rst2 = 1'b1; in_valid2 = 1'b0; in_left2 = '0; in_right2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_lrck", 64'(lrck), 64'd0);
    check("rst_sdata", 64'(sdata), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    rst = 1'b0;

    // Pair accepted mid frame 0, sent in frame 1; frame 2 underruns.
    idle(40);
    offer(16'hA5C3, 16'h0F01);
    idle(300);

    // Back-to-back with in_valid held high (junk while not ready).
    junk_en = 1'b1;
    offer(16'h8000, 16'h7FFF);
    offer(16'hFFFF, 16'h0001);
    idle(300);

    // Random pairs with random gaps and random junk behaviour.
    repeat (12) begin
      junk_en = 1'($urandom_range(0, 1));
      offer(W'($urandom), W'($urandom));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 200)));
    end
    idle(3 * FRAME);
    check("drain", 64'(exp_q.size()), 64'd0);

    // Reset at slot 20 of a data frame with another pair pending.
    junk_en = 1'b0;
    offer(16'h1234, 16'hFFFF);
    offer(16'h5A5A, 16'hC3C3);
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while ((p % FRAME != 20 * DIV) && (n < 2 * FRAME));
    check("pre_rst_lrck", 64'(lrck), 64'd1);
    check("pre_rst_sdata", 64'(sdata), 64'd1);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_sck", 64'(sck), 64'd0);
    check("mid_rst_lrck", 64'(lrck), 64'd0);
    check("mid_rst_sdata", 64'(sdata), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2 * FRAME + 10);

    // 24-bit, /2 instance: one pair accepted right after reset.
    @(posedge clk); #1;
    rst2 = 1'b0;
    check("w24_rdy_rst", 64'(in_ready2), 64'd1);
    in_valid2 = 1'b1;
    in_left2  = W2'($urandom);
    in_right2 = W2'($urandom);
    pair2     = {in_left2, in_right2};
    e_sck = 0; e_lr = 0; e_sd = 0; e_pulse = 0;
    for (int e = 1; e <= 2 * FRAME2 + 8; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        in_valid2 = 1'b0;
        check("w24_rdy_acc", 64'(in_ready2), 64'd0);
      end
      slot   = (e % FRAME2) / DIV2;
      exp_sd = (e >= FRAME2 && e < 2 * FRAME2) ? pair2[2*W2-1-(e-FRAME2)/DIV2] : 1'b0;
      if (sck2 !== 1'(e % 2)) e_sck++;
      if (lrck2 !== ((slot >= W2 - 1) && (slot <= 2 * W2 - 2))) e_lr++;
      if (sdata2 !== exp_sd) e_sd++;
      if (e == FRAME2) begin
        check("w24_fs_96", 64'(frame_start2), 64'd1);
        check("w24_ur_96", 64'(underrun2), 64'd0);
        check("w24_rdy_96", 64'(in_ready2), 64'd1);
      end else if (e == 2 * FRAME2) begin
        check("w24_fs_192", 64'(frame_start2), 64'd1);
        check("w24_ur_192", 64'(underrun2), 64'd1);
      end else if (frame_start2 || underrun2) begin
        e_pulse++;
      end
    end
    check("w24_sck_errs", 64'(e_sck), 64'd0);
    check("w24_lrck_errs", 64'(e_lr), 64'd0);
    check("w24_sdata_errs", 64'(e_sd), 64'd0);
    check("w24_pulse_errs", 64'(e_pulse), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
